// File: rtl/gpu2d_bg_tile_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : gpu2d_bg_tile_mem_arbiter_if
// Brief    : Renderer read, CPU write and tile-RAM port bundle for the arbiter.
// Revision : 1.0
// ============================================================================
interface gpu2d_bg_tile_mem_arbiter_if #(
  parameter int ADDR_WIDTH  = 12,
  parameter int PX_WIDTH    = 6,
  parameter int PX_PER_WORD = 16
);
  localparam int c_WORD_W = PX_WIDTH * PX_PER_WORD;

  logic                   io_rndrRdValid;
  logic [ADDR_WIDTH-1:0]  io_rndrRdAddr;
  logic                   io_rndrRdReady;
  logic                   io_rndrRspValid;
  logic [c_WORD_W-1:0]    io_rndrRspData;

  logic                   io_cpuWrValid;
  logic [ADDR_WIDTH-1:0]  io_cpuWrAddr;
  logic [c_WORD_W-1:0]    io_cpuWrData;
  logic [PX_PER_WORD-1:0] io_cpuWrMask;
  logic                   io_cpuWrReady;
  logic                   io_busy;

  logic                   io_ramWrEn;
  logic [ADDR_WIDTH-1:0]  io_ramWrAddr;
  logic [c_WORD_W-1:0]    io_ramWrData;
  logic                   io_ramRdEn;
  logic [ADDR_WIDTH-1:0]  io_ramRdAddr;
  logic [c_WORD_W-1:0]    io_ramRdData;

  // The arbiter itself.
  modport slave (
    input  io_rndrRdValid, io_rndrRdAddr, io_cpuWrValid, io_cpuWrAddr,
           io_cpuWrData, io_cpuWrMask, io_ramRdData,
    output io_rndrRdReady, io_rndrRspValid, io_rndrRspData, io_cpuWrReady,
           io_busy, io_ramWrEn, io_ramWrAddr, io_ramWrData, io_ramRdEn,
           io_ramRdAddr
  );

  // Clients plus the RAM, seen from outside the arbiter.
  modport master (
    output io_rndrRdValid, io_rndrRdAddr, io_cpuWrValid, io_cpuWrAddr,
           io_cpuWrData, io_cpuWrMask, io_ramRdData,
    input  io_rndrRdReady, io_rndrRspValid, io_rndrRspData, io_cpuWrReady,
           io_busy, io_ramWrEn, io_ramWrAddr, io_ramWrData, io_ramRdEn,
           io_ramRdAddr
  );
endinterface
`default_nettype wire

// File: rtl/gpu2d_bg_tile_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gpu2d_bg_tile_mem_arbiter
// Brief    : Shares the BG tile RAM read port between renderer and CPU RMW.
// Revision : 1.0
// ============================================================================
module gpu2d_bg_tile_mem_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int PX_WIDTH     = 6,
  parameter int PX_PER_WORD  = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
  gpu2d_bg_tile_mem_arbiter_if.slave   bus
);
  localparam int c_WORD_W = PX_WIDTH * PX_PER_WORD;
  localparam int c_CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_REQ  = 2'd1,
    S_RD_WAIT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [c_CNT_W-1:0]     starve_q, starve_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [c_WORD_W-1:0]    data_q, data_d;
  logic [PX_PER_WORD-1:0] mask_q, mask_d;
  logic                   rsp_valid_q;

  logic                   w_cpu_win;
  logic                   w_cpu_rd;
  logic                   w_cpu_ready;
  logic                   w_rndr_ready;
  logic                   w_rndr_hs;
  logic                   w_wr_en;
  logic [ADDR_WIDTH-1:0]  w_wr_addr;
  logic [c_WORD_W-1:0]    w_wr_data;
  logic [c_WORD_W-1:0]    w_merged;

  for (genvar gi = 0; gi < PX_PER_WORD; gi++) begin : g_merge
    assign w_merged[gi*PX_WIDTH +: PX_WIDTH] = mask_q[gi]
        ? data_q[gi*PX_WIDTH +: PX_WIDTH]
        : bus.io_ramRdData[gi*PX_WIDTH +: PX_WIDTH];
  end

  assign w_cpu_win = (state_q == S_RD_REQ) &&
                     (!bus.io_rndrRdValid || (starve_q == c_LIMIT));

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mask_d      = mask_q;
    w_cpu_rd    = 1'b0;
    w_cpu_ready = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_addr   = bus.io_cpuWrAddr;
    w_wr_data   = bus.io_cpuWrData;
    unique case (state_q)
      S_IDLE: begin
        w_cpu_ready = 1'b1;
        if (bus.io_cpuWrValid) begin
          if (&bus.io_cpuWrMask) begin
            w_wr_en = 1'b1;
          end else if (|bus.io_cpuWrMask) begin
            addr_d  = bus.io_cpuWrAddr;
            data_d  = bus.io_cpuWrData;
            mask_d  = bus.io_cpuWrMask;
            state_d = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (w_cpu_win) begin
          w_cpu_rd = 1'b1;
          starve_d = '0;
          state_d  = S_RD_WAIT;
        end else if (starve_q != c_LIMIT) begin
          starve_d = starve_q + 1'b1;
        end
      end
      S_RD_WAIT: begin
        w_wr_en   = 1'b1;
        w_wr_addr = addr_q;
        w_wr_data = w_merged;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Nothing touches the RAM while reset is held; this also drops an RMW caught mid-flight.
    if (reset) begin
      w_cpu_rd    = 1'b0;
      w_cpu_ready = 1'b0;
      w_wr_en     = 1'b0;
    end
  end

  assign w_rndr_ready = !reset && !w_cpu_rd;
  assign w_rndr_hs    = bus.io_rndrRdValid && w_rndr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      rsp_valid_q <= w_rndr_hs;
    end
  end

  assign bus.io_rndrRdReady  = w_rndr_ready;
  assign bus.io_rndrRspValid = rsp_valid_q;
  assign bus.io_rndrRspData  = bus.io_ramRdData;
  assign bus.io_cpuWrReady   = w_cpu_ready;
  assign bus.io_busy         = (state_q != S_IDLE);
  assign bus.io_ramWrEn      = w_wr_en;
  assign bus.io_ramWrAddr    = w_wr_addr;
  assign bus.io_ramWrData    = w_wr_data;
  assign bus.io_ramRdEn      = w_cpu_rd || w_rndr_hs;
  assign bus.io_ramRdAddr    = w_cpu_rd ? addr_q : bus.io_rndrRdAddr;
endmodule
`default_nettype wire
